// File: rtl/pooling_controller.sv
// 2x2 stride-2 average pooling sequencer: reads each window from a synchronous input
// buffer, sums it and writes the truncated average to the output buffer in row-major order.
module pooling_controller #(
    parameter int N      = 5,
    parameter int DATA_W = 16,
    localparam int M      = N / 2,
    localparam int IN_AW  = $clog2(N * N),
    localparam int OUT_AW = (M * M > 1) ? $clog2(M * M) : 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_finish,
    output logic              o_in_rd_en,
    output logic [IN_AW-1:0]  o_in_addr,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_wr_en,
    output logic [OUT_AW-1:0] o_out_addr,
    output logic [DATA_W-1:0] o_out_data
);

    localparam int CW    = (M > 1) ? $clog2(M) : 1;
    localparam int ACC_W = DATA_W + 2;

    if (N < 2) begin : g_bad_n
        $error("pooling_controller: N must be >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_WAIT, S_WR, S_DONE
    } state_t;

    // Truncating divide by 4: bias negative sums by 3 before the arithmetic shift.
    function automatic logic [DATA_W-1:0] div4(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] t;
        t = a + (a[ACC_W-1] ? ACC_W'(2'd3) : ACC_W'(2'd0));
        return t[ACC_W-1:2];
    endfunction

    state_t              r_state;
    logic [CW-1:0]       r_i;
    logic [CW-1:0]       r_j;
    logic [ACC_W-1:0]    r_acc;
    logic                r_busy;
    logic                r_finish;
    logic                r_rd_en;
    logic [IN_AW-1:0]    r_in_addr;
    logic                r_wr_en;
    logic [OUT_AW-1:0]   r_out_addr;
    logic [DATA_W-1:0]   r_out_data;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_i_nxt;
    logic [CW-1:0]       w_j_nxt;
    logic [ACC_W-1:0]    w_acc_nxt;
    logic [ACC_W-1:0]    w_pix_ext;
    logic                w_busy_nxt;
    logic                w_finish_nxt;
    logic                w_rd_en_nxt;
    logic                w_row_lo;
    logic                w_col_lo;
    logic [IN_AW-1:0]    w_in_addr_nxt;
    logic                w_wr_en_nxt;
    logic [OUT_AW-1:0]   w_out_addr_nxt;
    logic [DATA_W-1:0]   w_out_data_nxt;

    assign w_pix_ext = {{2{i_in_data[DATA_W-1]}}, i_in_data};

    // Next state, window counters and accumulator.
    always_comb begin
        w_state_nxt = r_state;
        w_i_nxt     = r_i;
        w_j_nxt     = r_j;
        w_acc_nxt   = r_acc;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RD0;
                    w_i_nxt     = '0;
                    w_j_nxt     = '0;
                    w_acc_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD0: begin
                w_state_nxt = S_RD1;
                w_acc_nxt   = '0;
            end
            S_RD1: begin
                w_state_nxt = S_RD2;
                w_acc_nxt   = r_acc + w_pix_ext;
            end
            S_RD2: begin
                w_state_nxt = S_RD3;
                w_acc_nxt   = r_acc + w_pix_ext;
            end
            S_RD3: begin
                w_state_nxt = S_WAIT;
                w_acc_nxt   = r_acc + w_pix_ext;
            end
            S_WAIT: begin
                w_state_nxt = S_WR;
                w_acc_nxt   = r_acc + w_pix_ext;
            end
            S_WR: begin
                if (r_j < CW'(M - 1)) begin
                    w_j_nxt     = r_j + CW'(1'b1);
                    w_state_nxt = S_RD0;
                end else if (r_i < CW'(M - 1)) begin
                    w_j_nxt     = '0;
                    w_i_nxt     = r_i + CW'(1'b1);
                    w_state_nxt = S_RD0;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state.
    always_comb begin
        w_busy_nxt     = 1'b0;
        w_finish_nxt   = 1'b0;
        w_rd_en_nxt    = 1'b0;
        w_wr_en_nxt    = 1'b0;
        w_row_lo       = 1'b0;
        w_col_lo       = 1'b0;
        w_in_addr_nxt  = r_in_addr;
        w_out_addr_nxt = r_out_addr;
        w_out_data_nxt = r_out_data;
        case (w_state_nxt)
            S_RD0: begin
                w_busy_nxt  = 1'b1;
                w_rd_en_nxt = 1'b1;
            end
            S_RD1: begin
                w_busy_nxt  = 1'b1;
                w_rd_en_nxt = 1'b1;
                w_col_lo    = 1'b1;
            end
            S_RD2: begin
                w_busy_nxt  = 1'b1;
                w_rd_en_nxt = 1'b1;
                w_row_lo    = 1'b1;
            end
            S_RD3: begin
                w_busy_nxt  = 1'b1;
                w_rd_en_nxt = 1'b1;
                w_row_lo    = 1'b1;
                w_col_lo    = 1'b1;
            end
            S_WAIT: begin
                w_busy_nxt = 1'b1;
            end
            S_WR: begin
                w_busy_nxt     = 1'b1;
                w_wr_en_nxt    = 1'b1;
                w_out_addr_nxt = OUT_AW'(w_i_nxt) * OUT_AW'(M) + OUT_AW'(w_j_nxt);
                w_out_data_nxt = div4(w_acc_nxt);
            end
            S_DONE: begin
                w_finish_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
        // Row/col of the pixel are {2i+row_lo, 2j+col_lo}.
        if (w_rd_en_nxt) begin
            w_in_addr_nxt = IN_AW'({w_i_nxt, w_row_lo}) * IN_AW'(N) + IN_AW'({w_j_nxt, w_col_lo});
        end else begin
            w_in_addr_nxt = r_in_addr;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_rd_en    <= 1'b0;
            r_in_addr  <= '0;
            r_wr_en    <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_i        <= w_i_nxt;
            r_j        <= w_j_nxt;
            r_acc      <= w_acc_nxt;
            r_busy     <= w_busy_nxt;
            r_finish   <= w_finish_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_in_addr  <= w_in_addr_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_out_addr <= w_out_addr_nxt;
            r_out_data <= w_out_data_nxt;
        end
    end

    assign o_busy      = r_busy;
    assign o_finish    = r_finish;
    assign o_in_rd_en  = r_rd_en;
    assign o_in_addr   = r_in_addr;
    assign o_out_wr_en = r_wr_en;
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;

endmodule

// File: doc/pooling_controller.md
Name: pooling_controller

Overview:
- Sequences 2x2, stride-2 average pooling over an NxN signed 16-bit feature map held in an external input buffer with a synchronous read port.
- Reads the four pixels of each window, accumulates them, divides by 4 and writes one result per window to an output buffer in row-major order.
- Uses a level start/finish handshake that matches the existing pooling datapath, so the layer sequencer can drive it the same way.

Parameters:
- N, 5, input map side length; must be >= 2 (elaboration error otherwise).
- DATA_W, 16, pixel width, signed two's complement.
- M, N/2 (floor), output map side; derived, not overridable.
- IN_AW, $clog2(N*N), input address width; derived.
- OUT_AW, max(1,$clog2(M*M)), output address width; derived.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  level request to run one full pooling pass.
- busy  out  1  high while a pass is in progress.
- finish  out  1  high from pass completion until start goes low.
- in_rd_en  out  1  input buffer read strobe.
- in_addr  out  IN_AW  input read address, row*N+col.
- in_data  in  DATA_W  read data, valid the cycle after in_rd_en.
- out_wr_en  out  1  output buffer write strobe, one cycle per window.
- out_addr  out  OUT_AW  output address, i*M+j.
- out_data  out  DATA_W  pooled pixel.

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE; busy, finish, in_rd_en and out_wr_en are 0; in_addr, out_addr, out_data, accumulator and window counters are 0. Reset mid-pass aborts the pass immediately, with no further reads or writes.
- States: IDLE, RD0, RD1, RD2, RD3, WAIT, WR, DONE.
- IDLE: if start=1 -> RD0 with window (i,j)=(0,0) and accumulator cleared.
- RD0..RD3: in_rd_en=1, one state each, in the order in_addr = (2i)*N+2j, (2i)*N+2j+1, (2i+1)*N+2j, (2i+1)*N+2j+1. Sequence is RD0->RD1->RD2->RD3->WAIT.
- Accumulation: in_data is sign-extended into an 18-bit accumulator in the cycle after each read (RD1, RD2, RD3, WAIT).
- WAIT: final add. -> WR.
- WR: out_wr_en=1, out_addr=i*M+j, out_data = acc/4, signed division truncating toward zero (add 3 before the arithmetic shift when acc<0). The result always fits DATA_W. Then:
  - if j<M-1: j++ -> RD0;
  - else if i<M-1: j=0, i++ -> RD0;
  - else -> DONE.
- DONE: finish=1, busy=0. Stays in DONE while start=1; start=0 -> IDLE with finish=0 on the next cycle.
- busy=1 in RD0..WR. in_rd_en and out_wr_en are 0 in all states not listed above.
- Throughput: 6 cycles per window. First in_rd_en occurs the cycle after start is sampled high. finish rises the cycle after the last out_wr_en. Total = 6*M*M+1 cycles from start sampled to finish.
- Odd N: the last row and column are never read (floor behaviour).
- Start changes: start deasserted mid-pass is ignored and the pass completes, then DONE->IDLE immediately. start held high through DONE does not retrigger; a new pass needs start low then high.
- in_addr and out_addr hold their last value when their strobe is low; out_data holds its last written value.

Test Plan:
- N=4, pixel[k]=k (k=0..15), start held high -> writes (addr,data) = (0,2),(1,4),(2,10),(3,12). Exactly 4 out_wr_en pulses, 16 in_rd_en pulses, finish at cycle 25 after start sampled, busy low thereafter.
- N=4, window (0,0) pixels = -1,-2,-3,-3 -> out_data at addr 0 = -2 (truncation toward zero, not -3).
- N=4, all pixels 32767 -> every output 32767. All pixels -32768 -> every output -32768 (no overflow).
- N=5, random 0..99 -> 4 writes to addresses 0..3. Each value equals the floor average of its 2x2 window. No in_addr with row 4 or column 4 is ever issued.
- Handshake and reset:
  - start held high after finish -> finish stays 1 with no new reads; start=0 -> finish=0 next cycle; start=1 again -> a new pass starts.
  - rst_n=0 asserted during RD2 of window 1 -> next cycle all strobes 0, busy=0, state IDLE, no further writes.
